// File: rtl/display_pkg.sv
// Shared types and 7-segment constants for the display scan controller.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high.
package display_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes above 9 render as a dash.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    // NOTE: every path assigns o_seg (default arm included), so no latch is inferred.
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS common-cathode digits over one shared segment bus with double-buffered BCD input.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros on digits above index 0.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        digits_valid,
  output logic                        digits_ready,
  output logic [SEG_W-1:0]            segmentos_out,
  output logic [NUM_DIGITS-1:0]       anodos_out,
  output logic                        frame_done
);

  localparam int DATA_W = BCD_W * NUM_DIGITS;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           r_state;
  logic [CNT_W-1:0]      r_slot_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_shadow;
  logic [DATA_W-1:0]     r_pending;
  logic                  r_pending_full;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_anodos;
  logic                  r_frame_done;

  logic                  w_capture;
  logic                  w_frame_end;
  logic                  w_commit;
  logic [BCD_W-1:0]      w_digit;
  logic [SEG_W-1:0]      w_seg_raw;
  logic [SEG_W-1:0]      w_seg;
  logic [NUM_DIGITS-1:0] w_anode;

  assign w_capture   = digits_valid && !r_pending_full;
  assign w_frame_end = (r_state == SHOW) && (r_slot_cnt == SLOT_LAST) && (r_idx == IDX_LAST);
  // A full pending buffer is released only at a frame edge, or straight away while dark.
  assign w_commit    = r_pending_full && ((r_state == IDLE) || (enable && w_frame_end));
  assign w_digit     = r_shadow[r_idx*BCD_W +: BCD_W];
  assign w_anode     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  bcd_to_seg7 u_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg_raw)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic w_lz_blank;

  always_comb begin
    w_lz_blank = (r_idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(r_idx)) && (r_shadow[i*BCD_W +: BCD_W] != '0)) w_lz_blank = 1'b0;
    end
  end

  assign w_seg = w_lz_blank ? SEG_OFF : w_seg_raw;
`else
  assign w_seg = w_seg_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_slot_cnt     <= '0;
      r_idx          <= '0;
      // NOTE: the digit buffers are plain flops, so they are reset like any other state.
      r_shadow       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_seg          <= SEG_OFF;
      r_anodos       <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so every branch reads pre-edge values.
      r_frame_done <= 1'b0;
      if (w_capture) begin
        r_pending      <= digits_in;
        r_pending_full <= 1'b1;
      end
      if (w_commit) begin
        r_shadow       <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (!enable) begin
        r_state    <= IDLE;
        r_slot_cnt <= '0;
        r_idx      <= '0;
        r_seg      <= SEG_OFF;
        r_anodos   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= BLANK;
            r_slot_cnt <= '0;
            r_idx      <= '0;
          end
          BLANK: begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
            if (r_slot_cnt == BLANK_LAST) begin
              r_state  <= SHOW;
              r_anodos <= w_anode;
              r_seg    <= w_seg;
            end
          end
          SHOW: begin
            if (r_slot_cnt == SLOT_LAST) begin
              r_state      <= BLANK;
              r_slot_cnt   <= '0;
              r_anodos     <= '0;
              r_seg        <= SEG_OFF;
              r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
              r_frame_done <= (r_idx == IDX_LAST);
            end else begin
              r_slot_cnt <= r_slot_cnt + 1'b1;
              r_anodos   <= w_anode;
              r_seg      <= w_seg;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign digits_ready  = !r_pending_full;
  assign segmentos_out = r_seg;
  assign anodos_out    = r_anodos;
  assign frame_done    = r_frame_done;

endmodule
